// File: rtl/systolic_feeder.sv
// Operand feeder for a SIZE x SIZE systolic array: buffers A columns / B rows,
// then clears the array, streams skewed zero-padded operands, drains, and holds result-valid.
module systolic_feeder #(
    parameter int SIZE         = 8,
    parameter int I_BITS       = 8,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [SIZE*I_BITS-1:0] i_a_vec,
    input  logic [SIZE*I_BITS-1:0] i_b_vec,
    output logic [SIZE*I_BITS-1:0] o_a_full,
    output logic [SIZE*I_BITS-1:0] o_b_full,
    output logic                   o_array_reset,
    output logic                   o_busy,
    output logic                   o_result_valid,
    input  logic                   i_result_ack,
    output logic [2:0]             fsm_state
);

    localparam int STREAM_STEPS = 3*SIZE - 2;
    localparam int STEP_MAX     = (STREAM_STEPS > DRAIN_CYCLES) ? STREAM_STEPS : DRAIN_CYCLES;
    localparam int SW           = $clog2(STEP_MAX + 1);
    localparam int BW           = $clog2(SIZE) + 1;
    localparam logic [SW-1:0] STREAM_LAST = SW'(STREAM_STEPS - 1);
    localparam logic [SW-1:0] DRAIN_LAST  = SW'(DRAIN_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST   = BW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [BW-1:0]          beat_cnt, beat_n;
    logic [SW-1:0]          step_cnt, step_n;
    logic                   load_beat;
    logic [I_BITS-1:0]      a_buf [SIZE][SIZE];
    logic [I_BITS-1:0]      b_buf [SIZE][SIZE];
    logic [SIZE*I_BITS-1:0] a_skew, b_skew;

    // Handshake: a beat transfers on a rising edge where i_valid && o_ready;
    // o_ready is high only in LOAD, so beats offered in any other state are dropped.
    assign o_ready   = (state == S_LOAD) && !i_reset;
    assign fsm_state = state;

    always_comb begin
        state_n   = state;
        beat_n    = beat_cnt;
        step_n    = step_cnt;
        load_beat = 1'b0;
        case (state)
            S_LOAD: begin
                if (i_valid) begin
                    load_beat = 1'b1;
                    if (beat_cnt == BEAT_LAST) begin
                        state_n = S_CLEAR;
                        beat_n  = '0;
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_n = S_STREAM;
                step_n  = '0;
            end
            S_STREAM: begin
                if (step_cnt == STREAM_LAST) begin
                    state_n = S_DRAIN;
                    step_n  = '0;
                end else begin
                    step_n = step_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (step_cnt == DRAIN_LAST) begin
                    state_n = S_DONE;
                    step_n  = '0;
                end else begin
                    step_n = step_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (i_result_ack) state_n = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase
    end

    // Skew for the step about to be presented: lane i carries element k where i+k == step.
    always_comb begin
        a_skew = '0;
        b_skew = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int k = 0; k < SIZE; k++) begin
                if (int'(step_n) == i + k) begin
                    a_skew[I_BITS*i +: I_BITS] = a_buf[i][k];
                    b_skew[I_BITS*i +: I_BITS] = b_buf[k][i];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (load_beat) begin
            for (int k = 0; k < SIZE; k++) begin
                if (int'(beat_cnt) == k) begin
                    for (int i = 0; i < SIZE; i++) begin
                        a_buf[i][k] <= i_a_vec[I_BITS*i +: I_BITS];
                        b_buf[k][i] <= i_b_vec[I_BITS*i +: I_BITS];
                    end
                end
            end
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= S_LOAD;
            beat_cnt       <= '0;
            step_cnt       <= '0;
            o_a_full       <= '0;
            o_b_full       <= '0;
            o_array_reset  <= 1'b1;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            state          <= state_n;
            beat_cnt       <= beat_n;
            step_cnt       <= step_n;
            o_a_full       <= (state_n == S_STREAM) ? a_skew : '0;
            o_b_full       <= (state_n == S_STREAM) ? b_skew : '0;
            o_array_reset  <= (state_n == S_CLEAR);
            o_busy         <= (state_n == S_CLEAR) || (state_n == S_STREAM) || (state_n == S_DRAIN);
            o_result_valid <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder at SIZE=2: skew tables, handshake gaps,
// result hold/ack and asynchronous reset with the clock stopped.
module tb_systolic_feeder;

    localparam int SIZE   = 2;
    localparam int I_BITS = 8;
    localparam int DRAIN  = 8;
    localparam int W      = SIZE*I_BITS;

    logic         clk = 1'b0;
    logic         clk_en = 1'b1;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         ready;
    logic [W-1:0] a_vec = '0;
    logic [W-1:0] b_vec = '0;
    logic [W-1:0] a_full, b_full;
    logic         array_reset, busy, result_valid;
    logic         result_ack = 1'b0;
    logic [2:0]   fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t load_tab [2][SIZE];
    vec_t exp_tab  [2][3*SIZE-2];

    always #5 if (clk_en) clk = ~clk;

    systolic_feeder #(.SIZE(SIZE), .I_BITS(I_BITS), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_a_vec       (a_vec),
        .i_b_vec       (b_vec),
        .o_a_full      (a_full),
        .o_b_full      (b_full),
        .o_array_reset (array_reset),
        .o_busy        (busy),
        .o_result_valid(result_valid),
        .i_result_ack  (result_ack),
        .fsm_state     (fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_beat(input vec_t v);
        valid = 1'b1;
        a_vec = v.a;
        b_vec = v.b;
        tick();
        valid = 1'b0;
    endtask

    // Entered right after the last accepted beat (state CLEAR); ends in DONE.
    task automatic check_stream(input int set);
        chk("clear_state", {29'd0, fsm_state}, 32'd1);
        chk("clear_arst", {31'd0, array_reset}, 32'd1);
        chk("clear_ready", {31'd0, ready}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        chk("clear_a", {16'd0, a_full}, 32'd0);
        for (int t = 0; t < 3*SIZE-2; t++) begin
            tick();
            chk($sformatf("stream_a_t%0d", t), {16'd0, a_full}, {16'd0, exp_tab[set][t].a});
            chk($sformatf("stream_b_t%0d", t), {16'd0, b_full}, {16'd0, exp_tab[set][t].b});
            chk($sformatf("stream_arst_t%0d", t), {31'd0, array_reset}, 32'd0);
        end
        for (int d = 0; d < DRAIN; d++) begin
            tick();
            chk($sformatf("drain_ab_%0d", d), {a_full, b_full}, 32'd0);
            chk($sformatf("drain_rv_%0d", d), {31'd0, result_valid}, 32'd0);
            chk($sformatf("drain_busy_%0d", d), {31'd0, busy}, 32'd1);
        end
        tick();
        chk("done_rv", {31'd0, result_valid}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_state", {29'd0, fsm_state}, 32'd4);
        chk("done_ready", {31'd0, ready}, 32'd0);
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_rv", {31'd0, result_valid}, 32'd0);
        chk("ack_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // A=[[1,2],[3,4]] B=[[5,6],[7,8]]; lane 0 in the low byte
        load_tab[0][0] = '{a: 16'h0301, b: 16'h0605};
        load_tab[0][1] = '{a: 16'h0402, b: 16'h0807};
        exp_tab[0][0]  = '{a: 16'h0001, b: 16'h0005};
        exp_tab[0][1]  = '{a: 16'h0302, b: 16'h0607};
        exp_tab[0][2]  = '{a: 16'h0400, b: 16'h0800};
        exp_tab[0][3]  = '{a: 16'h0000, b: 16'h0000};
        // A=[[9,10],[11,12]] B=[[13,14],[15,16]]
        load_tab[1][0] = '{a: 16'h0B09, b: 16'h0E0D};
        load_tab[1][1] = '{a: 16'h0C0A, b: 16'h100F};
        exp_tab[1][0]  = '{a: 16'h0009, b: 16'h000D};
        exp_tab[1][1]  = '{a: 16'h0B0A, b: 16'h0E0F};
        exp_tab[1][2]  = '{a: 16'h0C00, b: 16'h1000};
        exp_tab[1][3]  = '{a: 16'h0000, b: 16'h0000};

        // Power-up reset
        tick();
        tick();
        chk("rst_state", {29'd0, fsm_state}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_arst", {31'd0, array_reset}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_ab", {a_full, b_full}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_arst", {31'd0, array_reset}, 32'd0);

        // Gap-free load and full stream
        for (int k = 0; k < SIZE; k++) load_beat(load_tab[0][k]);
        check_stream(0);

        // Result held without ack
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("hold_rv_%0d", c), {31'd0, result_valid}, 32'd1);
        end

        // Ack with a simultaneous beat: only the ack is taken
        valid = 1'b1;
        a_vec = 16'hDEAD;
        b_vec = 16'hBEEF;
        ack_result();
        valid = 1'b0;
        chk("ack_state", {29'd0, fsm_state}, 32'd0);

        // Gapped load, then i_valid held high with junk through the stream
        load_beat(load_tab[1][0]);
        a_vec = 16'h5A5A;
        b_vec = 16'hA5A5;
        tick();
        tick();
        chk("gap_state", {29'd0, fsm_state}, 32'd0);
        load_beat(load_tab[1][1]);
        valid = 1'b1;
        a_vec = 16'h7777;
        b_vec = 16'h9999;
        check_stream(1);
        valid = 1'b0;
        ack_result();

        // Ack outside DONE has no effect
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("stray_ack_state", {29'd0, fsm_state}, 32'd0);

        // Reset mid-STREAM at t=3, asserted while the clock is stopped
        for (int k = 0; k < SIZE; k++) load_beat(load_tab[1][k]);
        for (int t = 0; t < 4; t++) tick();
        chk("pre_rst_state", {29'd0, fsm_state}, 32'd2);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        clk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", {29'd0, fsm_state}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_arst", {31'd0, array_reset}, 32'd1);
        chk("async_ready", {31'd0, ready}, 32'd0);
        chk("async_ab", {a_full, b_full}, 32'd0);
        clk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rerst_ready", {31'd0, ready}, 32'd1);
        chk("rerst_arst", {31'd0, array_reset}, 32'd0);

        // Fresh load after reset
        for (int k = 0; k < SIZE; k++) load_beat(load_tab[0][k]);
        check_stream(0);
        ack_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream stage of systolic_processorVCounter. It accepts operand matrices A and B one vector per beat over a valid/ready handshake and buffers them. It then clears the array and streams diagonally skewed, zero-padded A rows and B columns onto the array's i_a_full/i_b_full buses. It waits a drain period and flags the array result o_c_full as valid until acknowledged.

Parameters:
SIZE, 8, matrix dimension (array is SIZE x SIZE)
I_BITS, 8, operand element width
DRAIN_CYCLES, 8, cycles after last stream step before result is flagged valid (>=1)

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  load beat valid
o_ready  out  1  feeder can accept a load beat
i_a_vec  in  SIZE*I_BITS  column k of A: lane i = A[i][k]
i_b_vec  in  SIZE*I_BITS  row k of B: lane j = B[k][j]
o_a_full  out  SIZE*I_BITS  skewed A stream to array i_a_full
o_b_full  out  SIZE*I_BITS  skewed B stream to array i_b_full
o_array_reset  out  1  drives array i_reset (accumulator clear)
o_busy  out  1  high in CLEAR, STREAM, DRAIN
o_result_valid  out  1  array o_c_full holds A*B
i_result_ack  in  1  consumer has taken the result

Behaviour:
- Lane packing on all vector buses: lane n occupies bits [I_BITS*n +: I_BITS], matching the array.
- Reset (async, i_reset=1): state=LOAD, beat/step counters=0, o_a_full=0, o_b_full=0, o_array_reset=1, o_busy=0, o_result_valid=0, o_ready=0 while reset is asserted. Buffer contents are don't-care.
- All outputs are registered (no combinational path from inputs to outputs) except o_ready, which is decoded from the state register only.
- FSM states and transitions:
  - LOAD: o_ready=1, o_array_reset=0.
    - Each cycle with i_valid=1 stores i_a_vec into A buffer column beat_cnt and i_b_vec into B buffer row beat_cnt, then increments beat_cnt.
    - The SIZE-th accepted beat moves to CLEAR and resets beat_cnt.
  - CLEAR: exactly 1 cycle. o_array_reset=1, o_a_full=o_b_full=0, o_ready=0. Then moves to STREAM.
  - STREAM: exactly 3*SIZE-2 cycles, step t=0..3*SIZE-3. In the cycle of step t:
    - o_a_full lane i = A[i][t-i] if 0<=t-i<SIZE, else 0.
    - o_b_full lane j = B[t-j][j] if 0<=t-j<SIZE, else 0.
    - After the last step, moves to DRAIN.
  - DRAIN: DRAIN_CYCLES cycles with o_a_full=o_b_full=0. Then moves to DONE.
  - DONE: o_result_valid=1 and outputs stay zero. i_result_ack=1 moves to LOAD, and o_result_valid=0 from the next cycle.
- o_ready is 0 outside LOAD. i_valid in any other state is ignored and nothing is stored.
- In DONE, i_valid together with i_result_ack: only the ack is taken. The first beat can be accepted in the following cycle.
- i_result_ack outside DONE is ignored.
- Counters: beat_cnt is $clog2(SIZE)+1 bits. step_cnt is wide enough for max(3*SIZE-2, DRAIN_CYCLES) and is reused for DRAIN. Neither counter wraps: each is cleared on its state exit.
- Reset mid-operation (any state): immediate return to the reset values. Buffered beats are discarded and the array is cleared via o_array_reset=1.
- The feeder performs no arithmetic. The array's O_BITS=(2*I_BITS)+$clog2(SIZE) covers the full dot-product range.

Test Plan:
- Reset: assert i_reset mid-cycle with the clock stopped -> outputs go to reset values without a clock edge: o_array_reset=1, o_ready=0, o_a_full=0.
- SIZE=2 load and skew: A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats (a=[1,3], b=[5,6]) then (a=[2,4], b=[7,8]).
  - Expect CLEAR for 1 cycle with o_array_reset=1, then stream a/b lanes {lane0,lane1}:
  - t0: a={1,0}, b={5,0}
  - t1: a={2,3}, b={7,6}
  - t2: a={0,4}, b={0,8}
  - t3: zeros
  - Then 8 DRAIN cycles, then o_result_valid=1.
- End-to-end SIZE=8 with the array: random A/B; after o_result_valid, array o_c_full XOR golden matrix == 0 for all 64 entries.
- Handshake gaps: i_valid toggled 1,0,0,1,...; only cycles with i_valid=1 are stored, giving the same stream as the gap-free load. i_valid held during STREAM changes nothing.
- Result hold and ack: o_result_valid stays 1 for 20 cycles with no ack; ack together with i_valid -> beat ignored, o_ready=1 next cycle.
- Reset mid-STREAM at t=3 -> state LOAD, o_busy=0, o_array_reset=1. A fresh load after reset produces the correct skewed stream.
